// File: rtl/transparency_blend_pipeline.sv
// Two-stage multi-channel A/B pixel blender with selectable modes and a
// frame-stepped fade engine that ramps the shared A-proportion toward a target.
module transparency_blend_pipeline #(
  parameter int CHANNEL_WIDTH          = 8,
  parameter int NUM_CHANNELS           = 3,
  parameter int TRANSPARENCY_PRECISION = 4,
  parameter int ROUND                  = 0
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    in_valid,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   src_a_in,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   src_b_in,
  input  logic [1:0]                              mode,
  input  logic                                    frame_start,
  input  logic                                    fade_load,
  input  logic [TRANSPARENCY_PRECISION:0]         fade_target,
  input  logic [TRANSPARENCY_PRECISION:0]         fade_step,
  output logic [TRANSPARENCY_PRECISION:0]         proportion,
  output logic                                    fading,
  output logic                                    out_valid,
  output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   channel_out
);

  // Handshake: in_valid qualifies one pixel per cycle; there is no backpressure,
  // and out_valid is in_valid delayed exactly two cycles (dropped by reset).

  localparam int CW = CHANNEL_WIDTH;
  localparam int P  = TRANSPARENCY_PRECISION;
  localparam int PW = NUM_CHANNELS * CHANNEL_WIDTH;
  localparam int SW = P + CW + 1;

  localparam logic [P:0]    FULL    = {1'b1, {P{1'b0}}};
  localparam logic [CW-1:0] CH_MAX  = '1;
  localparam logic [SW-1:0] RND     = (ROUND != 0) ? (SW'(1) << (P - 1)) : SW'(0);

  localparam logic [1:0] MODE_BLEND = 2'd0;
  localparam logic [1:0] MODE_A     = 2'd1;
  localparam logic [1:0] MODE_B     = 2'd2;
  localparam logic [1:0] MODE_ADD   = 2'd3;

  typedef enum logic {IDLE, FADING} fade_state_t;

  fade_state_t state;
  logic [P:0]  target_q;
  logic [P:0]  step_q;
  logic [P:0]  target_c;
  logic        step_up;
  logic [P:0]  step_dist;
  logic        step_last;
  logic [P:0]  step_val;

  assign target_c  = (fade_target > FULL) ? FULL : fade_target;
  assign step_up   = (target_q > proportion);
  assign step_dist = step_up ? (target_q - proportion) : (proportion - target_q);
  // A step that would reach or pass the target lands exactly on it.
  assign step_last = (step_dist <= step_q);
  assign step_val  = step_last ? target_q :
                     (step_up ? (proportion + step_q) : (proportion - step_q));
  assign fading    = (state == FADING);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      proportion <= FULL;
      target_q   <= FULL;
      step_q     <= '0;
    end else if (fade_load) begin
      target_q <= target_c;
      step_q   <= fade_step;
      if (fade_step == '0) begin
        proportion <= target_c;
        state      <= IDLE;
      end else begin
        state <= (target_c == proportion) ? IDLE : FADING;
      end
    end else if ((state == FADING) && frame_start) begin
      proportion <= step_val;
      if (step_last) state <= IDLE;
    end
  end

  logic          s1_valid;
  logic [PW-1:0] s1_a;
  logic [PW-1:0] s1_b;
  logic [1:0]    s1_mode;
  logic [P:0]    s1_pa;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= MODE_BLEND;
      s1_pa    <= FULL;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= src_a_in;
        s1_b    <= src_b_in;
        s1_mode <= mode;
        s1_pa   <= proportion;
      end
    end
  end

  logic [PW-1:0] result;

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
    logic [CW-1:0] a_c;
    logic [CW-1:0] b_c;
    logic [SW-1:0] prod_a;
    logic [SW-1:0] prod_b;
    logic [SW-1:0] blend_sh;
    logic [SW-1:0] add_sum;
    logic [CW-1:0] blend_sat;
    logic [CW-1:0] add_sat;

    assign a_c       = s1_a[ch*CW +: CW];
    assign b_c       = s1_b[ch*CW +: CW];
    assign prod_a    = SW'(a_c) * SW'(s1_pa);
    assign prod_b    = SW'(b_c) * SW'(FULL - s1_pa);
    assign blend_sh  = (prod_a + prod_b + RND) >> P;
    assign add_sum   = (prod_a >> P) + SW'(b_c);
    assign blend_sat = (blend_sh > SW'(CH_MAX)) ? CH_MAX : blend_sh[CW-1:0];
    assign add_sat   = (add_sum > SW'(CH_MAX)) ? CH_MAX : add_sum[CW-1:0];

    assign result[ch*CW +: CW] = (s1_mode == MODE_A)   ? a_c :
                                 (s1_mode == MODE_B)   ? b_c :
                                 (s1_mode == MODE_ADD) ? add_sat : blend_sat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      channel_out <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) channel_out <= result;
    end
  end

endmodule

// File: tb/tb_transparency_blend_pipeline.sv
// Directed bench for transparency_blend_pipeline: truncating and rounding
// instances share stimulus; a monitor pops per-instance expected queues.
module tb_transparency_blend_pipeline;

  localparam int CW = 8;
  localparam int NC = 3;
  localparam int P  = 4;
  localparam int PW = NC * CW;

  localparam logic [1:0] BLEND = 2'd0;
  localparam logic [1:0] APASS = 2'd1;
  localparam logic [1:0] BPASS = 2'd2;
  localparam logic [1:0] ADD   = 2'd3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [PW-1:0] src_a_in;
  logic [PW-1:0] src_b_in;
  logic [1:0]    mode;
  logic          frame_start;
  logic          fade_load;
  logic [P:0]    fade_target;
  logic [P:0]    fade_step;
  logic [P:0]    proportion,  proportion_r;
  logic          fading,      fading_r;
  logic          out_valid,   out_valid_r;
  logic [PW-1:0] channel_out, channel_out_r;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] exp_r_q[$];
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  transparency_blend_pipeline #(.CHANNEL_WIDTH(CW), .NUM_CHANNELS(NC),
    .TRANSPARENCY_PRECISION(P), .ROUND(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .src_a_in(src_a_in),
    .src_b_in(src_b_in), .mode(mode), .frame_start(frame_start),
    .fade_load(fade_load), .fade_target(fade_target), .fade_step(fade_step),
    .proportion(proportion), .fading(fading), .out_valid(out_valid),
    .channel_out(channel_out));

  transparency_blend_pipeline #(.CHANNEL_WIDTH(CW), .NUM_CHANNELS(NC),
    .TRANSPARENCY_PRECISION(P), .ROUND(1)) dut_r (
    .clk(clk), .reset(reset), .in_valid(in_valid), .src_a_in(src_a_in),
    .src_b_in(src_b_in), .mode(mode), .frame_start(frame_start),
    .fade_load(fade_load), .fade_target(fade_target), .fade_step(fade_step),
    .proportion(proportion_r), .fading(fading_r), .out_valid(out_valid_r),
    .channel_out(channel_out_r));

  function automatic logic [PW-1:0] px(input int c2, input int c1, input int c0);
    return {8'(c2), 8'(c1), 8'(c0)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented output must match the oldest expected pixel.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL stale_out_trunc: got 0x%0h expected no output", channel_out);
      end else begin
        check("pixel_trunc", 32'(channel_out), 32'(exp_q.pop_front()));
      end
    end
    if (out_valid_r === 1'b1) begin
      if (exp_r_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL stale_out_round: got 0x%0h expected no output", channel_out_r);
      end else begin
        check("pixel_round", 32'(channel_out_r), 32'(exp_r_q.pop_front()));
      end
    end
  end

  // All driver tasks start and end on a falling edge.
  task automatic send(input logic [PW-1:0] a, input logic [PW-1:0] b, input logic [1:0] m,
                      input logic [PW-1:0] e_trunc, input logic [PW-1:0] e_round);
    in_valid = 1'b1; src_a_in = a; src_b_in = b; mode = m;
    exp_q.push_back(e_trunc);
    exp_r_q.push_back(e_round);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic fade(input int target, input int step, input logic fs);
    fade_load = 1'b1; fade_target = 5'(target); fade_step = 5'(step); frame_start = fs;
    @(negedge clk);
    fade_load = 1'b0; frame_start = 1'b0;
  endtask

  task automatic set_pa(input int v);
    fade(v, 0, 1'b0);
    check("set_pa", 32'(proportion), 32'(v));
  endtask

  task automatic frame(input string name, input int exp_p, input logic exp_f);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check(name, 32'(proportion), 32'(exp_p));
    check({name, "_fading"}, 32'(fading), 32'(exp_f));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; src_a_in = '0; src_b_in = '0; mode = BLEND;
    frame_start = 1'b0; fade_load = 1'b0; fade_target = '0; fade_step = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_channel_out", 32'(channel_out), 0);
    check("rst_proportion", 32'(proportion), 16);
    check("rst_fading", 32'(fading), 0);
    reset = 1'b0;

    // Latency and midpoint
    set_pa(8);
    send(px(255, 255, 255), px(255, 255, 255), BLEND, px(255, 255, 255), px(255, 255, 255));
    check("lat_one_cycle", 32'(out_valid), 0);
    @(negedge clk);
    check("lat_two_cycles", 32'(out_valid), 1);
    @(negedge clk);
    check("lat_single_pulse", 32'(out_valid), 0);

    // Truncation vs rounding
    send(px(255, 201, 200), px(0, 100, 100), BLEND, px(127, 150, 150), px(128, 151, 150));
    set_pa(4);
    send(px(255, 201, 200), px(0, 100, 100), BLEND, px(63, 125, 125), px(64, 125, 125));

    // Modes
    set_pa(16);
    send(px(10, 50, 200), px(250, 100, 100), ADD,   px(255, 150, 255), px(255, 150, 255));
    send(px(10, 50, 200), px(250, 100, 100), APASS, px(10, 50, 200),   px(10, 50, 200));
    send(px(10, 50, 200), px(250, 100, 100), BPASS, px(250, 100, 100), px(250, 100, 100));
    send(px(10, 50, 200), px(250, 100, 100), BLEND, px(10, 50, 200),   px(10, 50, 200));
    set_pa(8);
    send(px(10, 50, 200), px(250, 100, 100), ADD,   px(255, 125, 200), px(255, 125, 200));
    set_pa(0);
    send(px(10, 50, 200), px(250, 100, 100), BLEND, px(250, 100, 100), px(250, 100, 100));
    repeat (3) @(negedge clk);

    // Fade ramp
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("ramp_rst_proportion", 32'(proportion), 16);
    fade(0, 5, 1'b0);
    check("ramp_load_hold", 32'(proportion), 16);
    check("ramp_load_fading", 32'(fading), 1);
    frame("ramp_1", 11, 1'b1);
    frame("ramp_2", 6, 1'b1);
    frame("ramp_3", 1, 1'b1);
    frame("ramp_4", 0, 1'b0);
    frame("ramp_5", 0, 1'b0);

    // Fade edge cases
    fade(20, 0, 1'b0);
    check("clamp_proportion", 32'(proportion), 16);
    check("clamp_fading", 32'(fading), 0);
    fade(0, 4, 1'b0);
    frame("edge_down", 12, 1'b1);
    fade(16, 2, 1'b1);
    check("collide_no_step", 32'(proportion), 12);
    check("collide_fading", 32'(fading), 1);
    frame("retarget_1", 14, 1'b1);
    frame("retarget_2", 16, 1'b0);
    frame("idle_ignore", 16, 1'b0);

    // Reset mid-stream during a fade
    fade(0, 1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; mode = APASS; frame_start = 1'(i % 2);
      src_a_in = px(i * 17 + 3, i * 5 + 1, 250 - i); src_b_in = px(1, 2, 3);
      exp_q.push_back(src_a_in);
      exp_r_q.push_back(src_a_in);
      @(negedge clk);
    end
    reset = 1'b1; frame_start = 1'b0; src_a_in = px(9, 9, 9);
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_r_q.delete();
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_out_valid_round", 32'(out_valid_r), 0);
    check("midrst_proportion", 32'(proportion), 16);
    check("midrst_fading", 32'(fading), 0);
    reset = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_quiet", 32'(out_valid), 0);
    end
    send(px(7, 8, 9), px(1, 2, 3), APASS, px(7, 8, 9), px(7, 8, 9));
    repeat (4) @(negedge clk);

    check("drain_trunc", 32'(exp_q.size()), 0);
    check("drain_round", 32'(exp_r_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

endmodule

// File: doc/transparency_blend_pipeline.md
Name: transparency_blend_pipeline

Overview:
- Pipelined, multi-channel successor to the single-channel transparency mixer. It blends two pixel streams, A and B, with one shared A-proportion across NUM_CHANNELS packed colour channels.
- Adds selectable blend modes, optional rounding, a valid-tagged fixed-latency pipeline, and a frame-stepped fade engine that ramps the proportion toward a target.
- Sits in the pixel pipeline between the source fetchers and the output stage.

Parameters:
- CHANNEL_WIDTH, 8: bits per colour channel.
- NUM_CHANNELS, 3: packed channels per pixel; channel 0 is in the LSBs.
- TRANSPARENCY_PRECISION, 4: proportion fraction bits; full scale is 2^P, where P = TRANSPARENCY_PRECISION.
- ROUND, 0: 1 adds a half-LSB (2^(P-1)) before the shift; 0 truncates.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  pixel qualifier for src_a_in and src_b_in.
- src_a_in  in  NUM_CHANNELS*CHANNEL_WIDTH  source A pixel.
- src_b_in  in  NUM_CHANNELS*CHANNEL_WIDTH  source B pixel.
- mode  in  2  0 blend, 1 A pass, 2 B pass, 3 additive.
- frame_start  in  1  one-cycle pulse per frame; advances the fade.
- fade_load  in  1  one-cycle pulse; latches fade_target and fade_step.
- fade_target  in  P+1  target A-proportion; values above 2^P clamp to 2^P.
- fade_step  in  P+1  per-frame increment; 0 means jump immediately.
- proportion  out  P+1  current A-proportion register.
- fading  out  1  high while the fade engine is in FADING.
- out_valid  out  1  qualifier for channel_out.
- channel_out  out  NUM_CHANNELS*CHANNEL_WIDTH  result pixel.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is synchronous and active-high.
  - Reset values: out_valid=0, channel_out=0, proportion=2^P (full A), fading=0, FSM=IDLE, all pipeline valids=0.
- Pipeline:
  - Two stages, fixed latency of 2 cycles from in_valid to out_valid. No backpressure.
  - Stage 1 registers the pixels, mode, in_valid and the proportion value current at that edge.
  - Stage 2 computes the result and registers channel_out and out_valid.
  - channel_out holds its last value while out_valid=0.
- Arithmetic, per channel (a, b = channel values; pa = sampled proportion; pb = 2^P - pa):
  - Blend: sum = a*pa + b*pb + R, width P+CHANNEL_WIDTH+1, where R = 2^(P-1) if ROUND else 0. Output = sum>>P, saturated to 2^CHANNEL_WIDTH - 1.
  - A pass: output = a. B pass: output = b.
  - Additive: output = min(((a*pa)>>P) + b, 2^CHANNEL_WIDTH - 1).
  - pa=2^P gives exactly a in blend mode; pa=0 gives exactly b.
- Fade FSM, states IDLE and FADING:
  - fade_load with fade_step=0: proportion <= clamped target next cycle; state becomes or remains IDLE.
  - fade_load with fade_step!=0:
    - Latch the clamped target and the step.
    - If target equals proportion, stay IDLE; otherwise go to FADING.
    - proportion is unchanged that cycle.
  - FADING on frame_start: proportion moves toward target by step, clamped so it never overshoots. If the new value equals target, go to IDLE. fading drops in the cycle after the final step.
  - Simultaneous fade_load and frame_start: the load wins and no step occurs that cycle.
  - fade_load during FADING retargets from the current proportion.
  - frame_start in IDLE is ignored.
- Proportion timing:
  - A change to proportion affects only pixels whose in_valid edge occurs after the change.
  - Pixels already in the pipeline keep the value they sampled.
- Reset mid-operation:
  - In-flight pixels are dropped; out_valid=0 on the cycle after the reset edge.
  - The fade is aborted and proportion returns to 2^P.

Test Plan (CHANNEL_WIDTH=8, NUM_CHANNELS=3, P=4):
1. Latency and midpoint: ROUND=0, pa=8, blend, every channel a=255, b=255, single-cycle in_valid -> out_valid high exactly 2 cycles later; every channel 255.
2. Truncation vs rounding at pa=8 (a1 = channel 1, a2 = channel 2):
   - Channel 0: a=200, b=100 -> 150.
   - Channel 1: a1=201, b=100 -> 150 with ROUND=0; 151 with ROUND=1.
   - Channel 2: a2=255, b=0 at pa=4 -> 63 with ROUND=0; 64 with ROUND=1.
3. Fade ramp:
   - After reset, proportion=16.
   - fade_load with target=0, step=5, then four frame_start pulses -> proportion 11, 6, 1, 0.
   - fading is high from the cycle after the load and low after the 4th pulse.
   - A 5th frame_start leaves proportion at 0.
4. Fade edge cases:
   - fade_target=20 with step=0 -> proportion=16 (clamped) next cycle; fading stays 0.
   - fade_load and frame_start in the same cycle during FADING -> no step; the new target is latched.
5. Modes at pa=16:
   - Additive, a=200, b=100 -> 255 (saturated).
   - A pass -> 200. B pass -> 100.
   - Blend at pa=0 -> 100.
6. Reset mid-stream: continuous in_valid during a fade, reset asserted for 1 cycle -> out_valid=0, proportion=16 and fading=0 on the next cycle; no stale pixel emitted afterwards.
